// File: rtl/bram_ip_debounce.sv
// 32x8 simple dual-port block RAM whose write port also fires once per debounced
// pushbutton press. Optional macro BRAM_WR_BYPASS_EN selects new-data read-during-write.
`timescale 1ns/1ps

module bram_ip_debounce #(
  parameter int DATA_W          = 8,
  parameter int ADDR_W          = 5,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              button,
  output logic              button_pressed,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] wraddress,
  input  logic [ADDR_W-1:0] rdaddress,
  input  logic              wren,
  output logic [DATA_W-1:0] q
);

  localparam int DEPTH       = 2 ** ADDR_W;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sync_out;
  logic [CNT_W-1:0]       cnt_reg;
  logic                   db_state_reg;
  logic                   button_pressed_reg;
  logic                   wr_en;
  logic [DATA_W-1:0]      q_reg;
  logic [DATA_W-1:0]      q_next;
  logic [DATA_W-1:0]      mem [DEPTH];

  // Synchronizer flops idle high so a released button looks stable through reset.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], button};
    end
  end

  assign sync_out = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg            <= '0;
      db_state_reg       <= 1'b1;
      button_pressed_reg <= 1'b0;
    end else begin
      button_pressed_reg <= 1'b0;
      if (sync_out == db_state_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        // Accept the new level; only the 1->0 (press) transition pulses.
        db_state_reg       <= sync_out;
        cnt_reg            <= '0;
        button_pressed_reg <= db_state_reg;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign button_pressed = button_pressed_reg;

  // Reset also blocks external writes, not just the pulse path.
  assign wr_en = reset_n & (wren | button_pressed_reg);

  always_ff @(posedge CLOCK_50) begin
    if (wr_en) begin
      mem[wraddress] <= data;
    end
  end

  always_comb begin
    q_next = mem[rdaddress];
`ifdef BRAM_WR_BYPASS_EN
    if (wr_en && (wraddress == rdaddress)) begin
      q_next = data;
    end
`endif
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      q_reg <= '0;
    end else begin
      q_reg <= q_next;
    end
  end

  assign q = q_reg;

endmodule

// File: tb/tb_bram_ip_debounce.sv
// Randomized self-checking bench for bram_ip_debounce (DEBOUNCE_CYCLES = 16) with a
// window-based debounce model and a word-array RAM model.
`timescale 1ns/1ps

module tb_bram_ip_debounce;

  localparam int N = 16;
`ifdef BRAM_WR_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       button;
  logic       button_pressed;
  logic [7:0] data;
  logic [4:0] wraddress;
  logic [4:0] rdaddress;
  logic       wren;
  logic [7:0] q;

  int checks   = 0;
  int failures = 0;

  // Reference state
  logic [7:0] mem_m [32];
  bit         valid_m [32];
  bit         raw_q [$];
  bit         dly_q [$];
  bit         db_m;
  bit         pulse_pend;
  logic [7:0] exp_q;
  bit         exp_q_known;
  bit         exp_bp;

  bram_ip_debounce #(.DATA_W(8), .ADDR_W(5), .DEBOUNCE_CYCLES(N)) dut (
    .CLOCK_50      (clk),
    .reset_n       (reset_n),
    .button        (button),
    .button_pressed(button_pressed),
    .data          (data),
    .wraddress     (wraddress),
    .rdaddress     (rdaddress),
    .wren          (wren),
    .q             (q)
  );

  always #10 clk = ~clk;

  function automatic void model_reset();
    raw_q.delete();
    dly_q.delete();
    db_m       = 1'b1;
    pulse_pend = 1'b0;
  endfunction

  // The debounced level flips when the last N synchronized samples (raw input two
  // clocks earlier) all disagree with it; a flip to 0 is a press.
  function automatic bit model_edge(bit b);
    bit d;
    bit all_diff;
    raw_q.push_back(b);
    d = (raw_q.size() >= 3) ? raw_q[raw_q.size()-3] : 1'b1;
    if (raw_q.size() > 3) void'(raw_q.pop_front());
    dly_q.push_back(d);
    if (dly_q.size() > N) void'(dly_q.pop_front());
    all_diff = (dly_q.size() == N);
    foreach (dly_q[i]) if (dly_q[i] == db_m) all_diff = 1'b0;
    if (all_diff) begin
      db_m = d;
      return !d;
    end
    return 1'b0;
  endfunction

  // One clock: capture inputs, advance past the edge, update expectations.
  task automatic cycle();
    bit         b  = button;
    bit         we = wren | pulse_pend;
    logic [7:0] d  = data;
    logic [4:0] wa = wraddress;
    logic [4:0] ra = rdaddress;
    @(posedge clk);
    #1;
    exp_q_known = valid_m[ra] || (BYPASS && we && (wa == ra));
    exp_q       = (BYPASS && we && (wa == ra)) ? d : mem_m[ra];
    if (we) begin
      mem_m[wa]   = d;
      valid_m[wa] = 1'b1;
    end
    exp_bp     = model_edge(b);
    pulse_pend = exp_bp;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    button = 1'b1; wren = 1'b0; data = '0; wraddress = '0; rdaddress = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (q !== 8'h00) begin
      failures++; $display("FAIL reset_q actual=%h required=00", q);
    end
    checks++;
    if (button_pressed !== 1'b0) begin
      failures++; $display("FAIL reset_pulse actual=%b required=0", button_pressed);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    $display("test_reset done");
  endtask

  task automatic test_basic_write();
    wren = 1'b1; wraddress = 5'd3; data = 8'hA5; rdaddress = 5'd0;
    cycle();
    wren = 1'b0; rdaddress = 5'd3;
    cycle();
    checks++;
    if (q !== 8'hA5) begin
      failures++; $display("FAIL basic_read actual=%h required=a5", q);
    end
    $display("test_basic_write addr=3 q=%h", q);
  endtask

  task automatic test_fill();
    for (int a = 0; a < 32; a++) begin
      wren = 1'b1; wraddress = 5'(a); data = 8'($urandom); rdaddress = 5'd3;
      cycle();
      if (exp_q_known) begin
        checks++;
        if (q !== exp_q) begin
          failures++; $display("FAIL fill_read addr=%0d actual=%h required=%h", a, q, exp_q);
        end
      end
    end
    wren = 1'b0;
    $display("test_fill done");
  endtask

  task automatic test_random_rw();
    for (int i = 0; i < 200; i++) begin
      wren      = 1'($urandom_range(0, 1));
      wraddress = 5'($urandom);
      data      = 8'($urandom);
      rdaddress = ($urandom_range(0, 3) == 0) ? wraddress : 5'($urandom);
      cycle();
      checks++;
      if (q !== exp_q) begin
        failures++; $display("FAIL rand_read rd=%0d actual=%h required=%h", rdaddress, q, exp_q);
      end
      checks++;
      if (button_pressed !== exp_bp) begin
        failures++; $display("FAIL rand_pulse actual=%b required=%b", button_pressed, exp_bp);
      end
    end
    wren = 1'b0;
    $display("test_random_rw done");
  endtask

  task automatic test_rdw();
    logic [4:0] a;
    a = 5'($urandom);
    wren = 1'b1; wraddress = a; data = 8'h22; rdaddress = a ^ 5'd1;
    cycle();
    data = 8'h11; rdaddress = a;
    cycle();
    checks++;
    if (q !== (BYPASS ? 8'h11 : 8'h22)) begin
      failures++; $display("FAIL rdw_same actual=%h required=%h", q, BYPASS ? 8'h11 : 8'h22);
    end
    wren = 1'b0;
    cycle();
    checks++;
    if (q !== 8'h11) begin
      failures++; $display("FAIL rdw_after actual=%h required=11", q);
    end
    $display("test_rdw addr=%0d q=%h", a, q);
  endtask

  task automatic test_press();
    int pulses = 0;
    int pulse_at = -1;
    logic [4:0] wa;
    wa = 5'($urandom);
    wren = 1'b0; wraddress = wa; data = 8'h3C; rdaddress = wa ^ 5'd7;
    button = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      cycle();
      checks++;
      if (button_pressed !== exp_bp) begin
        failures++; $display("FAIL press_pulse cyc=%0d actual=%b required=%b", i, button_pressed, exp_bp);
      end
      if (button_pressed === 1'b1) begin
        pulses++;
        pulse_at = i;
      end
    end
    checks++;
    if (pulses != 1) begin
      failures++; $display("FAIL press_count actual=%0d required=1", pulses);
    end
    checks++;
    if (pulse_at != N + 2) begin
      failures++; $display("FAIL press_latency actual=%0d required=%0d", pulse_at, N + 2);
    end
    button = 1'b1;
    for (int i = 0; i < 30; i++) begin
      cycle();
      checks++;
      if (button_pressed !== 1'b0 || exp_bp) begin
        failures++; $display("FAIL release_pulse actual=%b required=0", button_pressed);
      end
    end
    rdaddress = wa;
    cycle();
    checks++;
    if (q !== 8'h3C) begin
      failures++; $display("FAIL press_write actual=%h required=3c", q);
    end
    $display("test_press addr=%0d pulse_at=%0d q=%h", wa, pulse_at, q);
  endtask

  task automatic test_glitch();
    int pulses = 0;
    logic [4:0] wa;
    wa = 5'($urandom);
    wren = 1'b1; wraddress = wa; data = 8'h5A; rdaddress = wa ^ 5'd1;
    cycle();
    wren = 1'b0; data = 8'hC3;
    button = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 10) button = 1'b1;
      cycle();
      if (button_pressed === 1'b1) pulses++;
      checks++;
      if (button_pressed !== exp_bp) begin
        failures++; $display("FAIL glitch_pulse cyc=%0d actual=%b required=%b", i, button_pressed, exp_bp);
      end
    end
    checks++;
    if (pulses != 0) begin
      failures++; $display("FAIL glitch_count actual=%0d required=0", pulses);
    end
    rdaddress = wa;
    cycle();
    checks++;
    if (q !== 8'h5A) begin
      failures++; $display("FAIL glitch_ram actual=%h required=5a", q);
    end
    $display("test_glitch addr=%0d pulses=%0d q=%h", wa, pulses, q);
  endtask

  task automatic test_bounce();
    for (int r = 0; r < 4; r++) begin
      int pulses = 0;
      int exp_pulses = 0;
      int len;
      bit lvl = 1'b0;
      logic [4:0] wa;
      wa = 5'($urandom);
      wren = 1'b0; wraddress = wa; data = 8'($urandom); rdaddress = wa ^ 5'd2;
      for (int seg = 0; seg < 10; seg++) begin
        len = (seg == 9) ? 30 : $urandom_range(1, 24);
        if (seg == 9) lvl = 1'b1;
        button = lvl;
        for (int i = 0; i < len; i++) begin
          cycle();
          if (button_pressed === 1'b1) pulses++;
          if (exp_bp) exp_pulses++;
          checks++;
          if (button_pressed !== exp_bp) begin
            failures++; $display("FAIL bounce_pulse round=%0d actual=%b required=%b", r, button_pressed, exp_bp);
          end
        end
        lvl = !lvl;
      end
      rdaddress = wa;
      cycle();
      if (exp_q_known) begin
        checks++;
        if (q !== exp_q) begin
          failures++; $display("FAIL bounce_ram addr=%0d actual=%h required=%h", wa, q, exp_q);
        end
      end
      $display("test_bounce round=%0d pulses=%0d expected=%0d", r, pulses, exp_pulses);
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    wren = 1'b1; wraddress = 5'd31; data = 8'hFF; rdaddress = 5'd0;
    cycle();
    wren = 1'b0; rdaddress = 5'd31;
    cycle();
    checks++;
    if (q !== 8'hFF) begin
      failures++; $display("FAIL mid_pre_q actual=%h required=ff", q);
    end
    button = 1'b0;
    repeat (8) cycle();
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (q !== 8'h00) begin
      failures++; $display("FAIL mid_async_q actual=%h required=00", q);
    end
    checks++;
    if (button_pressed !== 1'b0) begin
      failures++; $display("FAIL mid_async_pulse actual=%b required=0", button_pressed);
    end
    wren = 1'b1; wraddress = 5'd31; data = 8'h00; button = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (q !== 8'h00) begin
      failures++; $display("FAIL mid_hold_q actual=%h required=00", q);
    end
    reset_n = 1'b1;
    wren = 1'b0;
    model_reset();
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (button_pressed === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      failures++; $display("FAIL mid_no_pulse actual=%0d required=0", pulses);
    end
    checks++;
    if (q !== 8'hFF) begin
      failures++; $display("FAIL mid_ram_keep actual=%h required=ff", q);
    end
    $display("test_reset_mid pulses=%0d q=%h", pulses, q);
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_fill();
    test_random_rw();
    test_rdw();
    test_press();
    test_glitch();
    test_bounce();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
